// File: rtl/vid_crop_pack_pkg.sv
// rtl/vid_crop_pack_pkg.sv - shared video types, field offsets and RGB888->RGB555 rounding
package vid_crop_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } vid_state_e;

    localparam int R8_LSB = 16;
    localparam int G8_LSB = 8;
    localparam int B8_LSB = 0;
    localparam int R5_LSB = 10;
    localparam int G5_LSB = 5;
    localparam int B5_LSB = 0;

    // Round to nearest, saturating at 31 when the +4 carries into bit 8.
    function automatic logic [4:0] round_c8(input logic [7:0] c8);
        logic [8:0] sum;
        sum = {1'b0, c8} + 9'd4;
        return sum[8] ? 5'd31 : sum[7:3];
    endfunction

    function automatic logic [14:0] rgb888_to_555(input logic [23:0] px);
        logic [14:0] res;
        res = '0;
        res[R5_LSB +: 5] = round_c8(px[R8_LSB +: 8]);
        res[G5_LSB +: 5] = round_c8(px[G8_LSB +: 8]);
        res[B5_LSB +: 5] = round_c8(px[B8_LSB +: 8]);
        return res;
    endfunction

endpackage

// File: rtl/vid_crop_pack_px_counter.sv
// rtl/vid_crop_pack_px_counter.sv - column/row position counter with restart and last-pixel flag
module vid_crop_pack_px_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          restart,
    output logic [XW-1:0] col,
    output logic [YW-1:0] row,
    output logic          last
);

    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;

    // col_q/row_q hold the position of the next pixel; restart forces it to (0,0).
    always_comb begin
        col   = restart ? '0 : col_q;
        row   = restart ? '0 : row_q;
        last  = (col == XW'(H_ACTIVE - 1)) && (row == YW'(V_ACTIVE - 1));
        col_d = col_q;
        row_d = row_q;
        if (adv) begin
            if (col == XW'(H_ACTIVE - 1)) begin
                col_d = '0;
                row_d = last ? '0 : row + 1'b1;
            end else begin
                col_d = col + 1'b1;
                row_d = row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/vid_crop_pack.sv
// rtl/vid_crop_pack.sv - frame crop with optional 2:1 decimation and RGB555 packing, 2-cycle latency
module vid_crop_pack
    import vid_crop_pack_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          iCLK,
    input  logic          iRESETn,
    input  logic          iCFG_EN,
    input  logic [XW-1:0] iCFG_X0,
    input  logic [YW-1:0] iCFG_Y0,
    input  logic [XW-1:0] iCFG_W,
    input  logic [YW-1:0] iCFG_H,
    input  logic          iCFG_DEC,
    input  logic [23:0]   iVID_DATA,
    input  logic          iVID_DV,
    input  logic          iVID_START,
    output logic [14:0]   oVID_DATA,
    output logic          oVID_DV,
    output logic          oVID_START,
    output logic          oFRAME_DONE,
    output logic          oERR_OVF
);

    vid_state_e    state_q, state_d;
    logic          en_q, en_d, dec_q, dec_d, started_q, started_d, ovf_q, ovf_d;
    logic [XW-1:0] x0_q, x0_d, w_q, w_d;
    logic [YW-1:0] y0_q, y0_d, h_q, h_d;
    logic          s1_dv_q, s1_dv_d, s1_start_q, s1_start_d, s1_done_q, s1_done_d;
    logic [23:0]   s1_data_q, s1_data_d;
    logic          out_dv_q, out_dv_d, out_start_q, out_start_d, done_q, done_d;
    logic [14:0]   out_data_q, out_data_d;

    logic          start_px, proc, last, keep, in_x, in_y, dec_ok;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [XW:0]   x_end;
    logic [YW:0]   y_end;

    assign start_px = iVID_DV & iVID_START;
    assign proc     = start_px | (iVID_DV & (state_q == ST_ACTIVE));

    vid_crop_pack_px_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_px_counter (
        .clk     (iCLK),
        .rst_n   (iRESETn),
        .adv     (proc),
        .restart (start_px),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // The START pixel itself is judged against the config being captured on it.
    always_comb begin
        en_d  = start_px ? iCFG_EN  : en_q;
        x0_d  = start_px ? iCFG_X0  : x0_q;
        y0_d  = start_px ? iCFG_Y0  : y0_q;
        w_d   = start_px ? iCFG_W   : w_q;
        h_d   = start_px ? iCFG_H   : h_q;
        dec_d = start_px ? iCFG_DEC : dec_q;

        x_end  = {1'b0, x0_d} + {1'b0, w_d};
        y_end  = {1'b0, y0_d} + {1'b0, h_d};
        in_x   = (col >= x0_d) && ({1'b0, col} < x_end);
        in_y   = (row >= y0_d) && ({1'b0, row} < y_end);
        dec_ok = !dec_d || ((col[0] == x0_d[0]) && (row[0] == y0_d[0]));
        keep   = proc && en_d && in_x && in_y && dec_ok;

        started_d = start_px ? keep : (started_q | keep);
    end

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE:   if (proc) state_d = last ? ST_DONE : ST_ACTIVE;
            ST_ACTIVE: if (proc) state_d = last ? ST_DONE : ST_ACTIVE;
            ST_DONE: begin
                if (proc)         state_d = last ? ST_DONE : ST_ACTIVE;
                else if (iVID_DV) ovf_d   = 1'b1;
            end
            default:   state_d = ST_IDLE;
        endcase
        if (start_px) ovf_d = 1'b0;
    end

    always_comb begin
        s1_dv_d     = keep;
        s1_start_d  = keep && (start_px || !started_q);
        s1_done_d   = proc && last;
        s1_data_d   = keep ? iVID_DATA : s1_data_q;
        out_dv_d    = s1_dv_q;
        out_start_d = s1_start_q;
        done_d      = s1_done_q;
        out_data_d  = s1_dv_q ? rgb888_to_555(s1_data_q) : out_data_q;
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            dec_q       <= 1'b0;
            started_q   <= 1'b0;
            ovf_q       <= 1'b0;
            s1_dv_q     <= 1'b0;
            s1_start_q  <= 1'b0;
            s1_done_q   <= 1'b0;
            s1_data_q   <= '0;
            out_dv_q    <= 1'b0;
            out_start_q <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            dec_q       <= dec_d;
            started_q   <= started_d;
            ovf_q       <= ovf_d;
            s1_dv_q     <= s1_dv_d;
            s1_start_q  <= s1_start_d;
            s1_done_q   <= s1_done_d;
            s1_data_q   <= s1_data_d;
            out_dv_q    <= out_dv_d;
            out_start_q <= out_start_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
        end
    end

    assign oVID_DATA   = out_data_q;
    assign oVID_DV     = out_dv_q;
    assign oVID_START  = out_start_q;
    assign oFRAME_DONE = done_q;
    assign oERR_OVF    = ovf_q;

endmodule

// File: tb/tb_vid_crop_pack.sv
// tb/tb_vid_crop_pack.sv - randomized crop/pack checks against a frame-level reference model
module tb_vid_crop_pack;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int XW   = 11;
    localparam int YW   = 10;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iCFG_EN, iCFG_DEC, iVID_DV, iVID_START;
    logic [XW-1:0] iCFG_X0, iCFG_W;
    logic [YW-1:0] iCFG_Y0, iCFG_H;
    logic [23:0]   iVID_DATA;
    logic [14:0]   oVID_DATA;
    logic          oVID_DV, oVID_START, oFRAME_DONE, oERR_OVF;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [23:0] px[NPIX];

    vid_crop_pack #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
        .iCLK(clk), .iRESETn(rst_n),
        .iCFG_EN(iCFG_EN), .iCFG_X0(iCFG_X0), .iCFG_Y0(iCFG_Y0),
        .iCFG_W(iCFG_W), .iCFG_H(iCFG_H), .iCFG_DEC(iCFG_DEC),
        .iVID_DATA(iVID_DATA), .iVID_DV(iVID_DV), .iVID_START(iVID_START),
        .oVID_DATA(oVID_DATA), .oVID_DV(oVID_DV), .oVID_START(oVID_START),
        .oFRAME_DONE(oFRAME_DONE), .oERR_OVF(oERR_OVF)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (oVID_DV) got_q.push_back({oVID_START, oVID_DATA});
            if (oFRAME_DONE) done_cnt++;
        end
    end

    function automatic int c5(input int c8);
        int v;
        v = (c8 + 4) / 8;
        return (v > 31) ? 31 : v;
    endfunction

    function automatic logic [14:0] conv(input logic [23:0] p);
        return 15'((c5(int'(p[23:16])) << 10) | (c5(int'(p[15:8])) << 5) | c5(int'(p[7:0])));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic dv, input logic st, input logic [23:0] d);
        iVID_DV    = dv;
        iVID_START = st;
        iVID_DATA  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0);
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        exp_done = 0;
    endtask

    // Sends npix pixels of a frame (row-major from (0,0)) and records what should come out.
    task automatic send_frame(input bit en, input int x0, input int y0, input int w, input int h,
                              input bit dec, input int npix, input int gap_pct, input bit new_data);
        bit first_seen = 0;
        if (new_data)
            for (int i = 0; i < NPIX; i++) px[i] = 24'($urandom);
        iCFG_EN  = en;
        iCFG_X0  = XW'(x0);
        iCFG_Y0  = YW'(y0);
        iCFG_W   = XW'(w);
        iCFG_H   = YW'(h);
        iCFG_DEC = dec;
        for (int i = 0; i < npix; i++) begin
            int cx, ry;
            bit k;
            while (int'($urandom_range(99)) < gap_pct) step(1'b0, 1'b0, 24'($urandom));
            step(1'b1, i == 0, px[i]);
            if (i == 0) begin
                iCFG_EN  = 1'($urandom);
                iCFG_X0  = XW'($urandom);
                iCFG_Y0  = YW'($urandom);
                iCFG_W   = XW'($urandom);
                iCFG_H   = YW'($urandom);
                iCFG_DEC = 1'($urandom);
            end
            cx = (i % H) - x0;
            ry = (i / H) - y0;
            k  = en && cx >= 0 && cx < w && ry >= 0 && ry < h
                 && (!dec || ((cx % 2) == 0 && (ry % 2) == 0));
            if (k) begin
                exp_q.push_back({!first_seen, conv(px[i])});
                first_seen = 1;
            end
        end
        if (npix == NPIX) exp_done++;
        iVID_DV    = 1'b0;
        iVID_START = 1'b0;
    endtask

    task automatic check_out(input string tag, input int want_n);
        idle(4);
        if (want_n >= 0) chk({tag, "_count"}, got_q.size(), want_n);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_px%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_done"}, done_cnt, exp_done);
        clear_sb();
    endtask

    initial begin
        rst_n = 1'b0;
        iCFG_EN = 0; iCFG_X0 = 0; iCFG_Y0 = 0; iCFG_W = 0; iCFG_H = 0; iCFG_DEC = 0;
        iVID_DV = 0; iVID_START = 0; iVID_DATA = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", oVID_DATA, 0);
        chk("rst_dv", oVID_DV, 0);
        chk("rst_start", oVID_START, 0);
        chk("rst_done", oFRAME_DONE, 0);
        chk("rst_ovf", oERR_OVF, 0);
        rst_n = 1'b1;
        idle(2);

        // Two-cycle latency and rounding corner values
        iCFG_EN = 1; iCFG_X0 = 0; iCFG_Y0 = 0; iCFG_W = XW'(H); iCFG_H = YW'(V); iCFG_DEC = 0;
        step(1'b1, 1'b1, 24'hFF0304);
        chk("lat_e1_dv", oVID_DV, 0);
        step(1'b1, 1'b0, 24'h7C7C7C);
        chk("lat_e2_dv", oVID_DV, 1);
        chk("lat_e2_data", oVID_DATA, 15'h7C01);
        chk("lat_e2_start", oVID_START, 1);
        idle(1);
        chk("lat_e3_dv", oVID_DV, 1);
        chk("lat_e3_data", oVID_DATA, 15'h4210);
        chk("lat_e3_start", oVID_START, 0);
        idle(1);
        chk("lat_e4_dv", oVID_DV, 0);
        chk("lat_e4_hold", oVID_DATA, 15'h4210);
        clear_sb();

        // Window, decimated window, and same data with random gaps
        send_frame(1, 2, 1, 4, 2, 0, NPIX, 0, 1);
        check_out("win", 8);
        send_frame(1, 2, 1, 4, 2, 1, NPIX, 0, 0);
        check_out("dec", 2);
        send_frame(1, 2, 1, 4, 2, 0, NPIX, 50, 0);
        check_out("gaps", 8);

        // Overflow after frame end, cleared by next START
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'($urandom));
        idle(3);
        chk("ovf_set", oERR_OVF, 1);
        chk("ovf_no_out", got_q.size(), 0);
        send_frame(1, 0, 0, H, V, 0, NPIX, 20, 1);
        chk("ovf_clear", oERR_OVF, 0);
        check_out("after_ovf", NPIX);

        // Frame aborted by START at row 2 col 5, then a full frame
        send_frame(1, 1, 0, 5, 3, 0, 2 * H + 5, 30, 1);
        send_frame(1, 0, 2, 3, 2, 1, NPIX, 0, 1);
        check_out("short", -1);

        for (int f = 0; f < 6; f++) begin
            send_frame(($urandom % 4) != 0, $urandom_range(9), $urandom_range(5),
                       $urandom_range(10), $urandom_range(5), 1'($urandom),
                       NPIX, $urandom_range(60), 1);
            check_out($sformatf("rnd%0d", f), -1);
        end

        // Reset in the middle of a frame
        send_frame(1, 0, 0, H, V, 0, 13, 0, 1);
        rst_n = 1'b0;
        idle(2);
        chk("mid_rst_data", oVID_DATA, 0);
        chk("mid_rst_dv", oVID_DV, 0);
        chk("mid_rst_start", oVID_START, 0);
        chk("mid_rst_done", oFRAME_DONE, 0);
        chk("mid_rst_ovf", oERR_OVF, 0);
        rst_n = 1'b1;
        clear_sb();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 24'($urandom));
        idle(3);
        chk("idle_ignores", got_q.size(), 0);
        send_frame(1, 3, 1, 4, 3, 0, NPIX, 25, 1);
        check_out("post_rst", 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
